// File: rtl/stats_join_stage.sv
// Joins the min/max/avg result streams word-for-word into one record carrying
// avg, spread = max - min, an alarm flag and an order-error flag.
module stats_join_stage #(
  parameter int DATA_W     = 64,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] min_in_data,
  input  logic              min_in_valid,
  output logic              min_in_ready,
  input  logic [DATA_W-1:0] max_in_data,
  input  logic              max_in_valid,
  output logic              max_in_ready,
  input  logic [DATA_W-1:0] avg_in_data,
  input  logic              avg_in_valid,
  output logic              avg_in_ready,
  input  logic [DATA_W-1:0] alarm_thresh,
  output logic [DATA_W-1:0] stat_avg,
  output logic [DATA_W-1:0] stat_spread,
  output logic              stat_alarm,
  output logic              stat_order_err,
  output logic              stat_valid,
  input  logic              stat_ready,
  output logic [CNT_W-1:0]  rec_count,
  output logic              order_err_sticky
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int NS = 3;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

  // Stream index: 0 = min, 1 = max, 2 = avg
  logic [DATA_W-1:0] in_data [NS];
  logic [DATA_W-1:0] head    [NS];
  logic [NS-1:0]     in_valid;
  logic [NS-1:0]     in_ready;
  logic [NS-1:0]     nonempty;
  logic              join_fire;

  assign in_data[0] = min_in_data;
  assign in_data[1] = max_in_data;
  assign in_data[2] = avg_in_data;
  assign in_valid   = {avg_in_valid, max_in_valid, min_in_valid};
  assign min_in_ready = in_ready[0];
  assign max_in_ready = in_ready[1];
  assign avg_in_ready = in_ready[2];

  assign join_fire = (&nonempty) && (!stat_valid || stat_ready);

  generate
    for (genvar gi = 0; gi < NS; gi++) begin : g_fifo
      logic [DATA_W-1:0] mem [FIFO_DEPTH];
      logic [AW-1:0]     wr_ptr_reg;
      logic [AW-1:0]     rd_ptr_reg;
      logic [AW:0]       count_reg;
      logic              push;
      logic              pop;

      // Ready looks only at the registered count, never at a same-cycle pop.
      assign in_ready[gi] = !reset && (count_reg < DEPTH_C);
      assign push         = in_valid[gi] && in_ready[gi];
      assign pop          = join_fire;
      assign nonempty[gi] = (count_reg != '0);
      assign head[gi]     = mem[rd_ptr_reg];

      always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_reg] <= in_data[gi];
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          wr_ptr_reg <= '0;
          rd_ptr_reg <= '0;
          count_reg  <= '0;
        end else begin
          if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
          if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
          case ({push, pop})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
          endcase
        end
      end
    end
  endgenerate

  logic              max_ge_min;
  logic [DATA_W-1:0] spread_next;
  logic              alarm_next;
  logic              order_next;

  always_comb begin
    max_ge_min  = (head[1] >= head[0]);
    spread_next = max_ge_min ? (head[1] - head[0]) : '0;
    order_next  = !max_ge_min;
    alarm_next  = (spread_next > alarm_thresh);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_valid       <= 1'b0;
      stat_avg         <= '0;
      stat_spread      <= '0;
      stat_alarm       <= 1'b0;
      stat_order_err   <= 1'b0;
      rec_count        <= '0;
      order_err_sticky <= 1'b0;
    end else begin
      if (join_fire) begin
        stat_valid     <= 1'b1;
        stat_avg       <= head[2];
        stat_spread    <= spread_next;
        stat_alarm     <= alarm_next;
        stat_order_err <= order_next;
        if (order_next) order_err_sticky <= 1'b1;
      end else if (stat_valid && stat_ready) begin
        stat_valid <= 1'b0;
      end
      if (stat_valid && stat_ready) rec_count <= rec_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_stats_join_stage.sv
// Directed bench for stats_join_stage: single records, threshold edge, skew,
// backpressure, order error and mid-stream reset.
module tb_stats_join_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] min_in_data, max_in_data, avg_in_data, alarm_thresh;
  logic        min_in_valid, max_in_valid, avg_in_valid;
  logic        min_in_ready, max_in_ready, avg_in_ready;
  logic [63:0] stat_avg, stat_spread;
  logic        stat_alarm, stat_order_err, stat_valid, stat_ready;
  logic [31:0] rec_count;
  logic        order_err_sticky;

  int checks = 0;
  int errors = 0;

  stats_join_stage dut (
    .clk(clk), .reset(reset),
    .min_in_data(min_in_data), .min_in_valid(min_in_valid), .min_in_ready(min_in_ready),
    .max_in_data(max_in_data), .max_in_valid(max_in_valid), .max_in_ready(max_in_ready),
    .avg_in_data(avg_in_data), .avg_in_valid(avg_in_valid), .avg_in_ready(avg_in_ready),
    .alarm_thresh(alarm_thresh),
    .stat_avg(stat_avg), .stat_spread(stat_spread), .stat_alarm(stat_alarm),
    .stat_order_err(stat_order_err), .stat_valid(stat_valid), .stat_ready(stat_ready),
    .rec_count(rec_count), .order_err_sticky(order_err_sticky)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic drive(input logic [63:0] mn, input logic [63:0] mx, input logic [63:0] av,
                       input logic v);
    min_in_data = mn; max_in_data = mx; avg_in_data = av;
    min_in_valid = v; max_in_valid = v; avg_in_valid = v;
  endtask

  // One word on every stream; FIFOs are expected to have room.
  task automatic send_all(input logic [63:0] mn, input logic [63:0] mx, input logic [63:0] av);
    @(negedge clk);
    drive(mn, mx, av, 1'b1);
    @(posedge clk);
    #1;
    drive(mn, mx, av, 1'b0);
  endtask

  task automatic expect_rec(input string tag, input logic [63:0] av, input logic [63:0] sp,
                            input logic al, input logic oe, output int waited);
    waited = 0;
    do begin
      @(posedge clk);
      #1;
      waited++;
    end while (!stat_valid && waited < 20);
    check({tag, "_valid"}, 64'(stat_valid), 64'd1);
    check({tag, "_avg"}, stat_avg, av);
    check({tag, "_spread"}, stat_spread, sp);
    check({tag, "_alarm"}, 64'(stat_alarm), 64'(al));
    check({tag, "_oerr"}, 64'(stat_order_err), 64'(oe));
  endtask

  initial begin
    int w;
    reset = 1'b1;
    stat_ready = 1'b1;
    alarm_thresh = 64'd5;
    drive(64'd0, 64'd0, 64'd0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 64'(stat_valid), 64'd0);
    check("rst_rdy", 64'({min_in_ready, max_in_ready, avg_in_ready}), 64'd0);
    check("rst_cnt", 64'(rec_count), 64'd0);
    check("rst_sticky", 64'(order_err_sticky), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("post_rst_rdy", 64'({min_in_ready, max_in_ready, avg_in_ready}), 64'd7);

    // Single record with one-cycle latency
    send_all(64'd3, 64'd10, 64'd6);
    expect_rec("single", 64'd6, 64'd7, 1'b1, 1'b0, w);
    check("single_lat", 64'(w), 64'd1);
    @(posedge clk);
    #1;
    check("single_cnt", 64'(rec_count), 64'd1);
    check("single_drop", 64'(stat_valid), 64'd0);

    // Threshold is strict
    send_all(64'd0, 64'd5, 64'd1);
    expect_rec("thr_eq", 64'd1, 64'd5, 1'b0, 1'b0, w);
    send_all(64'd0, 64'd6, 64'd2);
    expect_rec("thr_gt", 64'd2, 64'd6, 1'b1, 1'b0, w);

    // Order error and sticky flag
    send_all(64'd20, 64'd8, 64'd3);
    expect_rec("oerr", 64'd3, 64'd0, 1'b0, 1'b1, w);
    check("oerr_sticky", 64'(order_err_sticky), 64'd1);
    send_all(64'd1, 64'd2, 64'd4);
    expect_rec("good_after", 64'd4, 64'd1, 1'b0, 1'b0, w);
    check("sticky_hold", 64'(order_err_sticky), 64'd1);
    @(posedge clk);
    #1;
    check("cnt_5", 64'(rec_count), 64'd5);

    // Skew: min/max fill while avg is idle
    alarm_thresh = 64'd200;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      min_in_data = 64'(i); max_in_data = 64'(i + 100);
      min_in_valid = 1'b1; max_in_valid = 1'b1;
      @(posedge clk);
    end
    #1;
    check("skew_full", 64'({min_in_ready, max_in_ready}), 64'd0);
    @(negedge clk);
    min_in_data = 64'd99; max_in_data = 64'd199;
    @(posedge clk);
    #1;
    check("skew_stall", 64'({min_in_ready, max_in_ready}), 64'd0);
    check("skew_noval", 64'(stat_valid), 64'd0);
    @(negedge clk);
    min_in_valid = 1'b0; max_in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      avg_in_data = 64'(50 + i);
      avg_in_valid = 1'b1;
      @(posedge clk);
      #1;
      if (i == 0) begin
        check("skew_lat0", 64'(stat_valid), 64'd0);
      end else begin
        check($sformatf("skew%0d_valid", i - 1), 64'(stat_valid), 64'd1);
        check($sformatf("skew%0d_avg", i - 1), stat_avg, 64'(49 + i));
        check($sformatf("skew%0d_spread", i - 1), stat_spread, 64'd100);
      end
    end
    @(negedge clk);
    avg_in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("skew3_valid", 64'(stat_valid), 64'd1);
    check("skew3_avg", stat_avg, 64'd53);
    @(posedge clk);
    #1;
    check("cnt_9", 64'(rec_count), 64'd9);
    check("skew_idle", 64'(stat_valid), 64'd0);

    // Backpressure: 12 records, consumer stalls for 10 cycles
    alarm_thresh = 64'd10;
    fork
      begin
        for (int k = 0; k < 12; k++) begin
          int b;
          @(negedge clk);
          drive(64'(k), 64'(3 * k + 2), 64'(k + 7), 1'b1);
          b = 0;
          while (!(min_in_ready && max_in_ready && avg_in_ready) && b < 100) begin
            @(negedge clk);
            b++;
          end
          if (b >= 100) check("bp_prod_timeout", 64'd0, 64'd1);
          @(posedge clk);
        end
        @(negedge clk);
        drive(64'd0, 64'd0, 64'd0, 1'b0);
      end
      begin
        int got;
        int cyc;
        got = 0;
        cyc = 0;
        while (got < 12 && cyc < 300) begin
          @(negedge clk);
          cyc++;
          stat_ready = !(cyc >= 3 && cyc < 13);
          if (cyc == 12) check("bp_inputs_stall", 64'(min_in_ready), 64'd0);
          if (stat_valid) begin
            check($sformatf("bp%0d_avg", got), stat_avg, 64'(got + 7));
            check($sformatf("bp%0d_spread", got), stat_spread, 64'(2 * got + 2));
            check($sformatf("bp%0d_alarm", got), 64'(stat_alarm), 64'((2 * got + 2) > 10));
            if (stat_ready) got++;
          end
        end
        if (got < 12) check("bp_cons_timeout", 64'(got), 64'd12);
      end
    join
    @(posedge clk);
    #1;
    check("bp_cnt", 64'(rec_count), 64'd21);
    check("bp_idle", 64'(stat_valid), 64'd0);

    // Reset with one record pending and two words buffered
    stat_ready = 1'b0;
    send_all(64'd1, 64'd2, 64'd3);
    send_all(64'd1, 64'd2, 64'd3);
    send_all(64'd1, 64'd2, 64'd3);
    check("pre_rst_valid", 64'(stat_valid), 64'd1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("mid_rst_valid", 64'(stat_valid), 64'd0);
    check("mid_rst_avg", stat_avg, 64'd0);
    check("mid_rst_spread", stat_spread, 64'd0);
    check("mid_rst_cnt", 64'(rec_count), 64'd0);
    check("mid_rst_rdy", 64'({min_in_ready, max_in_ready, avg_in_ready}), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rel_rdy", 64'({min_in_ready, max_in_ready, avg_in_ready}), 64'd7);
    check("rel_sticky", 64'(order_err_sticky), 64'd0);
    stat_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rel_discard", 64'(stat_valid), 64'd0);
    check("rel_cnt", 64'(rec_count), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got 0 expected 1");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/stats_join_stage.md
Name: stats_join_stage

Overview:
- Downstream consumer of the moving-average block's three result streams (min, max, avg), each a 64-bit data/valid/ready channel.
- Buffers each stream independently, aligns them word-for-word into one record, derives spread = max - min, flags out-of-range spread, and presents one combined valid/ready record to the host/readout stage.
- Tolerates skew between the three streams and backpressure from the consumer.

Parameters:
- DATA_W, 64, width of every data word.
- FIFO_DEPTH, 4, entries per input FIFO; power of two, at least 2.
- CNT_W, 32, width of the emitted-record counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- min_in_data  in  DATA_W  minimum value stream.
- min_in_valid  in  1  min word present.
- min_in_ready  out  1  min FIFO can accept.
- max_in_data / max_in_valid / max_in_ready  in/in/out  DATA_W/1/1  maximum stream, same rules as min.
- avg_in_data / avg_in_valid / avg_in_ready  in/in/out  DATA_W/1/1  average stream, same rules as min.
- alarm_thresh  in  DATA_W  spread threshold, sampled at each join.
- stat_avg  out  DATA_W  joined average.
- stat_spread  out  DATA_W  max - min, saturated at 0.
- stat_alarm  out  1  spread > alarm_thresh.
- stat_order_err  out  1  this record had max < min.
- stat_valid  out  1  record valid.
- stat_ready  in  1  consumer accepts.
- rec_count  out  CNT_W  records accepted by consumer, wraps.
- order_err_sticky  out  1  set by any record with max < min; cleared only by reset.

Behaviour:
- Reset (async assert, sync-released internally by flops on clk): all FIFO pointers and counts 0; stat_valid 0; stat_avg, stat_spread 0; stat_alarm, stat_order_err 0; rec_count 0; order_err_sticky 0; every *_in_ready 0 while reset is high.
- Handshake: a transfer occurs on a rising edge when valid && ready are both high. Producers may hold valid without ready. Data is stable while valid is high and ready is low.
- Input side: x_in_ready = (count_x < FIFO_DEPTH), derived from registered state only. It does not depend on same-cycle pops, so a full FIFO drops ready even if a pop happens in the same cycle.
- Each FIFO is circular: write pointer and read pointer wrap modulo FIFO_DEPTH. Count is updated for simultaneous push and pop (net unchanged).
- Join condition: all three FIFOs non-empty && (!stat_valid || stat_ready).
  - On that edge, pop one word from each FIFO and load the output register.
  - stat_avg = avg head.
  - If max >= min: spread = max - min (unsigned), order_err = 0. Otherwise: spread = 0, order_err = 1.
  - stat_alarm = spread > alarm_thresh (strict; equality gives 0).
  - stat_valid = 1.
- If stat_valid && stat_ready && join condition is false: stat_valid goes to 0; data registers hold their values.
- Latency: when the last of three aligned words is written at edge E, stat_valid is high after edge E+1 if the output register is free.
- Throughput: one record per cycle sustained when all streams are valid and stat_ready = 1.
- Output fields stay stable while stat_valid && !stat_ready.
- rec_count increments on each stat_valid && stat_ready edge; it wraps to 0 after 2^CNT_W - 1.
- order_err_sticky is set on the load edge of any record with order_err = 1.
- Skewed arrival: words pair strictly by FIFO order, never by timing. A stream running ahead fills its FIFO, then deasserts ready.
- Reset mid-operation: all buffered words and any pending record are discarded immediately. No output transfer completes on the reset edge.

Test Plan:
- Single record: min=3, max=10, avg=6, thresh=5, all valid for one cycle, stat_ready=1 -> one record: avg=6, spread=7, alarm=1, order_err=0; rec_count=1.
- Threshold edge: min=0, max=5, thresh=5 -> spread=5, alarm=0. Repeat with max=6 -> spread=6, alarm=1.
- Skew: min and max streams send 4 words each, avg held invalid -> min_in_ready and max_in_ready low after 4 accepts, no stat_valid. Then release avg with 4 words -> 4 records in FIFO order; first record stat_valid one cycle after the first avg write.
- Backpressure: continuous streams, stat_ready low for 10 cycles -> stat_valid held with stable fields, FIFOs fill, inputs stall. After release, no record is lost or duplicated; rec_count matches the number of records sent.
- Order error: min=20, max=8 -> spread=0, stat_order_err=1, order_err_sticky=1. The next good record has stat_order_err=0 and order_err_sticky stays 1.
- Reset mid-stream: assert reset with 2 words buffered and stat_valid=1 -> outputs go to 0 immediately. After release, all readies are high and rec_count=0.
